ops_stream_arbiter: RTL
=======================

# ops_stream_arbiter

Shares one `operations` reduction unit between R requester streams. Each requester presents a framed packet (`istart`..`ilast`) tagged with an opcode and input-select mask. The block grants one packet at a time in round-robin order and locks `opSelect`/`inputSelect` for the whole packet, including the result drain. It returns the result stream to the granted requester only. It sits between the MPI collective front-ends and the single `operations` instance.

## Interface
- `N`, 4: inputs per lane; matches `operations` `n`.
- `P`, 1: parallel lanes; matches `operations` `p`.
- `R`, 2: number of requesters, 2..8.
- `TIMEOUT`, 1024: watchdog limit in cycles. Used only when the watchdog is compiled in.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  asynchronous, active-low reset.
- `req_idata`  in  R·16·P·N  requester k data at `[k·16PN +: 16PN]`.
- `req_ivalid`, `req_istart`, `req_ilast`  in  R  per-requester stream control.
- `req_iready`  out  R  per-requester accept.
- `req_op`  in  3R  per-requester opcode, `[3k +: 3]`.
- `req_sel`  in  N·R  per-requester inputSelect, `[Nk +: N]`.
- `rsp_odata`  out  16P  result data, shared by all requesters.
- `rsp_ovalid`  out  R  result valid, one-hot to the granted requester.
- `rsp_oready`  in  R  per-requester result ready.
- `rsp_ostart`, `rsp_olast`  out  1  result framing.
- `op_opSelect`  out  3  to `operations`.
- `op_inputSelect`  out  N  to `operations`.
- `op_idata`  out  16PN  to `operations`.
- `op_ivalid`, `op_istart`, `op_ilast`  out  1  to `operations`.
- `op_iready`  in  1  from `operations`.
- `op_odata`  in  16P  from `operations`.
- `op_ovalid`, `op_ostart`, `op_olast`  in  1  from `operations`.
- `op_oready`  out  1  to `operations`.
- `grant_id`  out  $clog2(R)  index of the current owner.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  one-cycle watchdog pulse.

## Operation
- The state machine has four states: IDLE, SETUP, SEND, DRAIN.
- IDLE:
  - A requester is eligible when `req_ivalid[k] & req_istart[k]` is high.
  - The round-robin search starts at `last_grant+1`.
  - On any eligible requester: register `grant_id`, `op_opSelect <= req_op[g]` and `op_inputSelect <= req_sel[g]`, then go to SETUP.
  - `op_oready`=1 in IDLE. Stray result beats are consumed and dropped.
- SETUP:
  - Lasts exactly one cycle.
  - `op_ivalid`=0 and all `req_iready`=0.
  - The cycle lets the registered mux inside `operations` see the new opSelect before data arrives.
  - Always moves to SEND.
- SEND:
  - Input side is a combinational pass-through of requester g: `op_idata`, `op_ivalid`, `op_istart` and `op_ilast` come from g, and `req_iready[g]=op_iready`.
  - All other `req_iready` are 0.
  - Results may already flow back during SEND.
  - A handshake beat with `op_ilast` moves to DRAIN.
- DRAIN:
  - `op_ivalid`=0.
  - Results are forwarded: `rsp_ovalid[g]=op_ovalid` and `op_oready=rsp_oready[g]`.
  - A handshake beat with `op_olast` moves to IDLE and sets `last_grant<=g`.
- An `op_olast` handshake already seen during SEND is remembered. DRAIN then exits in its first cycle.
- `op_opSelect` and `op_inputSelect` are constant from SETUP through the DRAIN exit.
- Opcode 3'b110 is undefined and is registered as 3'b111 (pass-through).
- A non-granted requester holding `ivalid` without `istart` waits. It is never granted mid-packet.

## Timing
- Reset (asynchronous) forces:
  - state IDLE, `last_grant`=R-1 (so requester 0 wins first);
  - `op_opSelect`=3'b000, `op_inputSelect`=0, `grant_id`=0;
  - `busy`=0, `err`=0, all `rsp_ovalid`=0, `op_ivalid`=0.
- Reset mid-packet abandons the packet. No output is guarded beyond the reset values.
- Grant latency: request seen in IDLE at cycle t → SETUP at t+1 → first `op_ivalid` at t+2.
- Data path latency through the block is 0 cycles in both directions.
- The minimum gap between back-to-back packets is 2 cycles (IDLE + SETUP).
- Simultaneous eligible requests are resolved strictly round-robin. There is no starvation: each requester waits at most R-1 packets.

## Configuration
- Macro: `OPS_ARB_WATCHDOG_EN`.
- Defined:
  - A counter runs in SEND/DRAIN and clears on any input or output handshake.
  - When it reaches TIMEOUT, `err` pulses for one cycle, state goes to IDLE, and `last_grant<=g`.
- Undefined: no counter is built, `err` is tied 0, and the block waits indefinitely.

## Structure
- `ops_pkg` holds:
  - `op_e`: ADD=000, MUL=001, MIN=010, MAX=011, MEAN=100, AND=101, PASS=111;
  - the state enum `arb_state_e`;
  - the constant `OP_INVALID=3'b110`.
- One sub-module, `rr_arbiter`: R-bit request vector plus pointer in, one-hot grant and index out; purely combinational.

## Test plan
- After reset, requester 0 sends a 3-beat ADD packet, `req_sel`=4'b1111, inputs {1,2,3,4}. `op_opSelect`=000 one cycle before the first `op_ivalid`; `rsp_ovalid[0]` result 10; `rsp_ovalid[1]` stays 0.
- Requesters 0 and 1 start in the same cycle. Requester 0 is granted first; after its `olast`, requester 1 is granted with `op_opSelect` switching only in its SETUP cycle.
- Requester 1 issues opcode 3'b110. `op_opSelect`=3'b111 and the data is passed through.
- `rsp_oready[0]` is held low for 5 cycles during DRAIN. `op_oready` stays low for those cycles, no beats are lost, and `op_opSelect` is unchanged.
- With `OPS_ARB_WATCHDOG_EN` and TIMEOUT=8, `operations` never asserts `op_ovalid`. `err` pulses at the 8th idle cycle, state returns to IDLE, and the next requester is granted.
- Assert `aresetn` low mid-SEND. All outputs take their reset values asynchronously, and the next packet from requester 0 behaves as the first packet after reset.

Source files
------------

// File: rtl/ops_pkg.sv
// Shared types for the operations stream arbiter: opcode encoding, arbiter
// state encoding and the opcode clean-up helper.
package ops_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'b000,
        MUL  = 3'b001,
        MIN  = 3'b010,
        MAX  = 3'b011,
        MEAN = 3'b100,
        AND  = 3'b101,
        PASS = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SEND,
        DRAIN
    } arb_state_e;

    localparam logic [2:0] OP_INVALID = 3'b110;

    // The undefined encoding is steered to pass-through so the reduction unit
    // never sees an opcode it cannot decode.
    function automatic logic [2:0] op_sanitize(input logic [2:0] op);
        logic [2:0] res;
        if (op == OP_INVALID) begin
            res = PASS;
        end else begin
            res = op;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans the request vector starting one
// slot after the previous owner and returns the first hit as one-hot + index.
module rr_arbiter #(
    parameter int unsigned R = 2
) (
    input  logic [R-1:0]         i_req,
    input  logic [$clog2(R)-1:0] i_last,
    output logic [R-1:0]         o_gnt,
    output logic [$clog2(R)-1:0] o_idx
);

    localparam int unsigned IW = $clog2(R);

    logic [IW-1:0] w_k;

    // First requester found after i_last (wrapping) wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        w_k   = '0;
        for (int unsigned i = 1; i <= R; i++) begin
            w_k = IW'((32'(i_last) + i) % R);
            if (o_gnt == '0 && i_req[w_k]) begin
                o_gnt[w_k] = 1'b1;
                o_idx      = w_k;
            end
        end
    end

endmodule

// File: rtl/ops_stream_arbiter.sv
// Packet-level round-robin arbiter in front of a single `operations` unit.
// A granted requester keeps opSelect/inputSelect locked from SETUP until its
// result stream has drained; results are steered back to that requester only.
// Optional watchdog: define OPS_ARB_WATCHDOG_EN to build the stall counter.
module ops_stream_arbiter
    import ops_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned P       = 1,
    parameter int unsigned R       = 2,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [R*16*P*N-1:0]    req_idata,
    input  logic [R-1:0]           req_ivalid,
    input  logic [R-1:0]           req_istart,
    input  logic [R-1:0]           req_ilast,
    output logic [R-1:0]           req_iready,
    input  logic [3*R-1:0]         req_op,
    input  logic [N*R-1:0]         req_sel,
    output logic [16*P-1:0]        rsp_odata,
    output logic [R-1:0]           rsp_ovalid,
    input  logic [R-1:0]           rsp_oready,
    output logic                   rsp_ostart,
    output logic                   rsp_olast,
    output logic [2:0]             op_opSelect,
    output logic [N-1:0]           op_inputSelect,
    output logic [16*P*N-1:0]      op_idata,
    output logic                   op_ivalid,
    output logic                   op_istart,
    output logic                   op_ilast,
    input  logic                   op_iready,
    input  logic [16*P-1:0]        op_odata,
    input  logic                   op_ovalid,
    input  logic                   op_ostart,
    input  logic                   op_olast,
    output logic                   op_oready,
    output logic [$clog2(R)-1:0]   grant_id,
    output logic                   busy,
    output logic                   err
);

    localparam int unsigned GW = $clog2(R);
    localparam int unsigned DW = 16 * P * N;

    arb_state_e    r_state, w_state_d;
    logic [GW-1:0] r_last_grant;
    logic [GW-1:0] r_grant_id;
    logic [2:0]    r_op_sel;
    logic [N-1:0]  r_in_sel;
    logic          r_olast_seen;

    logic [R-1:0]  w_elig;
    logic [R-1:0]  w_gnt_oh;
    logic [GW-1:0] w_gnt_idx;
    logic          w_grant;
    logic          w_done;
    logic          w_olast_set;

`ifdef OPS_ARB_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    logic [WdW-1:0] r_wd_cnt;
    logic           r_err;
    logic           w_any_hs;
    logic           w_wd_hit;
`endif

    // Only a packet head may win arbitration; mid-packet beats never do.
    assign w_elig = req_ivalid & req_istart;

    rr_arbiter #(
        .R (R)
    ) u_rr (
        .i_req  (w_elig),
        .i_last (r_last_grant),
        .o_gnt  (w_gnt_oh),
        .o_idx  (w_gnt_idx)
    );

    // Zero-latency data paths; qualifiers are gated by the FSM below.
    assign op_idata       = req_idata[32'(r_grant_id)*DW +: DW];
    assign rsp_odata      = op_odata;
    assign rsp_ostart     = op_ostart;
    assign rsp_olast      = op_olast;
    assign op_opSelect    = r_op_sel;
    assign op_inputSelect = r_in_sel;
    assign grant_id       = r_grant_id;
    assign busy           = (r_state != IDLE);

    // Next state plus per-state steering of handshakes to the owner.
    always_comb begin
        w_state_d   = r_state;
        op_ivalid   = 1'b0;
        op_istart   = 1'b0;
        op_ilast    = 1'b0;
        op_oready   = 1'b0;
        req_iready  = '0;
        rsp_ovalid  = '0;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        w_olast_set = 1'b0;
`ifdef OPS_ARB_WATCHDOG_EN
        w_any_hs    = 1'b0;
        w_wd_hit    = 1'b0;
`endif
        unique case (r_state)
            IDLE: begin
                // Drop any stray result beats while nobody owns the unit.
                op_oready = 1'b1;
                if (w_gnt_oh != '0) begin
                    w_grant   = 1'b1;
                    w_state_d = SETUP;
                end
            end
            SETUP: begin
                // Gives the registered opSelect mux inside `operations` a cycle.
                w_state_d = SEND;
            end
            SEND: begin
                op_ivalid              = req_ivalid[r_grant_id];
                op_istart              = req_istart[r_grant_id];
                op_ilast               = req_ilast[r_grant_id];
                req_iready[r_grant_id] = op_iready;
                rsp_ovalid[r_grant_id] = op_ovalid;
                op_oready              = rsp_oready[r_grant_id];
                if (op_ovalid && rsp_oready[r_grant_id] && op_olast) begin
                    w_olast_set = 1'b1;
                end
                if (req_ivalid[r_grant_id] && op_iready && req_ilast[r_grant_id]) begin
                    w_state_d = DRAIN;
                end
`ifdef OPS_ARB_WATCHDOG_EN
                w_any_hs = (req_ivalid[r_grant_id] & op_iready) |
                           (op_ovalid & rsp_oready[r_grant_id]);
`endif
            end
            DRAIN: begin
                if (r_olast_seen) begin
                    w_state_d = IDLE;
                    w_done    = 1'b1;
                end else begin
                    rsp_ovalid[r_grant_id] = op_ovalid;
                    op_oready              = rsp_oready[r_grant_id];
                    if (op_ovalid && rsp_oready[r_grant_id] && op_olast) begin
                        w_state_d = IDLE;
                        w_done    = 1'b1;
                    end
`ifdef OPS_ARB_WATCHDOG_EN
                    w_any_hs = op_ovalid & rsp_oready[r_grant_id];
`endif
                end
            end
            default: w_state_d = IDLE;
        endcase
`ifdef OPS_ARB_WATCHDOG_EN
        if ((r_state == SEND || r_state == DRAIN) && !w_any_hs && !w_done &&
            r_wd_cnt == WdW'(TIMEOUT - 1)) begin
            w_wd_hit  = 1'b1;
            w_state_d = IDLE;
            w_done    = 1'b1;
        end
`endif
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Grant context: locked at grant time, held until the packet retires.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_grant_id <= '0;
            r_op_sel   <= 3'b000;
            r_in_sel   <= '0;
        end else if (w_grant) begin
            r_grant_id <= w_gnt_idx;
            r_op_sel   <= op_sanitize(req_op[3*w_gnt_idx +: 3]);
            r_in_sel   <= req_sel[N*w_gnt_idx +: N];
        end
    end

    // Remembers a result olast that finished before the input side did.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_olast_seen <= 1'b0;
        end else if (w_grant) begin
            r_olast_seen <= 1'b0;
        end else if (w_olast_set) begin
            r_olast_seen <= 1'b1;
        end
    end

    // Round-robin pointer; reset value makes requester 0 win first.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_last_grant <= GW'(R - 1);
        end else if (w_done) begin
            r_last_grant <= r_grant_id;
        end
    end

`ifdef OPS_ARB_WATCHDOG_EN
    // Stall counter: any handshake in either direction proves progress.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_wd_hit;
            if ((r_state == SEND || r_state == DRAIN) && !w_any_hs && !w_done) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end else begin
                r_wd_cnt <= '0;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
